// File: rtl/sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// sca_blk_alloc
//   Parametrised SCA block allocator. Keeps a free/used map of NBLK = 2**AW
//   SCA blocks, offers the next free block to the write controller and
//   accepts one allocate and one release per clock. After reset an INIT
//   sweep fills the map one block per clock; READY rises when it completes.
//
// Parameters
//   AW        block address width (NBLK = 2**AW)
//   RSVD_MASK bit i = 1 -> block i is reserved (never free, never allocated)
//   MODE      0: nearest free block circularly after RDADR; 1: lowest free index
//   TMR       1: free map, free counter and FSM state are triplicated and voted
//
// Ports
//   CLK, RST   clock, asynchronous active-high reset
//   RDADR      current block, search origin for MODE 0
//   ALLOC      1-cycle pulse: take block NADR
//   RLS        1-cycle pulse: free block RLS_ADR
//   RLS_ADR    block to release
//   CLR_ERR    synchronous clear of the sticky error flags
//   READY      initialisation sweep done
//   NADR       next free block (valid when !FULL)
//   NFREE      number of free blocks
//   FULL       no free block
//   FREE_MAP   free map, 1 = free
//   ERR_OVF    sticky: ALLOC while FULL or !READY
//   ERR_RLS    sticky: bad release, or RLS while !READY
// ---------------------------------------------------------------------------
module sca_blk_alloc #(
    parameter int unsigned           AW        = 4,
    parameter logic [(2**AW)-1:0]    RSVD_MASK = '0,
    parameter int unsigned           MODE      = 0,
    parameter int unsigned           TMR       = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [AW-1:0]        RDADR,
    input  logic                 ALLOC,
    input  logic                 RLS,
    input  logic [AW-1:0]        RLS_ADR,
    input  logic                 CLR_ERR,
    output logic                 READY,
    output logic [AW-1:0]        NADR,
    output logic [AW:0]          NFREE,
    output logic                 FULL,
    output logic [(2**AW)-1:0]   FREE_MAP,
    output logic                 ERR_OVF,
    output logic                 ERR_RLS
);

    localparam int unsigned NBLK   = 2**AW;
    localparam logic [AW:0] NF_ONE = (AW+1)'(1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Current (voted when TMR) and next values of the protected state
    logic [NBLK-1:0] free_v, free_d;
    logic [AW:0]     nfree_v, nfree_d;
    state_t          state_v, state_d;

    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   nadr_q, nadr_d;
    logic            full_q, full_d;
    logic            ready_q, ready_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_rls_q, err_rls_d;

    logic            alloc_ok, rls_ok, found;
    logic [AW-1:0]   idx;

    // ------------------------------------------------------------------
    // Map / counter / FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        free_d   = free_v;
        nfree_d  = nfree_v;
        state_d  = state_v;
        ptr_d    = ptr_q;
        alloc_ok = 1'b0;
        rls_ok   = 1'b0;
        if (state_v == S_INIT) begin
            free_d[ptr_q] = ~RSVD_MASK[ptr_q];
            if (!RSVD_MASK[ptr_q]) begin
                nfree_d = nfree_v + NF_ONE;
            end
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) begin
                state_d = S_RUN;
            end
        end else begin
            // FULL is the pre-edge registered flag, so ALLOC while FULL is
            // rejected even when a release lands in the same clock.
            alloc_ok = ALLOC && !full_q;
            rls_ok   = RLS && !free_v[RLS_ADR] && !RSVD_MASK[RLS_ADR];
            // nadr_q is free and RLS_ADR is used, so the two never collide
            if (alloc_ok) begin
                free_d[nadr_q] = 1'b0;
            end
            if (rls_ok) begin
                free_d[RLS_ADR] = 1'b1;
            end
            if (rls_ok && !alloc_ok) begin
                nfree_d = nfree_v + NF_ONE;
            end else if (alloc_ok && !rls_ok) begin
                nfree_d = nfree_v - NF_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-block search on the next-state map. Candidates are visited from
    // lowest to highest priority so the last hit is the winner.
    // ------------------------------------------------------------------
    always_comb begin
        nadr_d = nadr_q;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NBLK; i++) begin
            if (MODE == 0) begin
                // i=0 -> offset NBLK == RDADR itself (last resort),
                // i=NBLK-1 -> RDADR+1 (first choice)
                idx = RDADR + AW'(NBLK - i);
            end else begin
                idx = AW'(NBLK - 1 - i);
            end
            if (free_d[idx]) begin
                nadr_d = idx;
                found  = 1'b1;
            end
        end
        full_d = ~found;
    end

    // ------------------------------------------------------------------
    // Sticky errors: a new error in the same clock beats CLR_ERR
    // ------------------------------------------------------------------
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_rls_d = err_rls_q;
        if (CLR_ERR) begin
            err_ovf_d = 1'b0;
            err_rls_d = 1'b0;
        end
        if (ALLOC && !alloc_ok) begin
            err_ovf_d = 1'b1;
        end
        if (RLS && !rls_ok) begin
            err_rls_d = 1'b1;
        end
        ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q     <= '0;
            nadr_q    <= '0;
            full_q    <= 1'b1;
            ready_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_rls_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            nadr_q    <= nadr_d;
            full_q    <= full_d;
            ready_q   <= ready_d;
            err_ovf_q <= err_ovf_d;
            err_rls_q <= err_rls_d;
        end
    end

    // ------------------------------------------------------------------
    // Protected state storage
    // ------------------------------------------------------------------
    if (TMR != 0) begin : g_tmr
        logic [NBLK-1:0] free_r  [3];
        logic [AW:0]     nfree_r [3];
        state_t          state_r [3];

        // Each copy reloads from the voted next state, so a single upset is
        // scrubbed on the following clock.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    free_r[c]  <= '0;
                    nfree_r[c] <= '0;
                    state_r[c] <= S_INIT;
                end
            end else begin
                for (int unsigned c = 0; c < 3; c++) begin
                    free_r[c]  <= free_d;
                    nfree_r[c] <= nfree_d;
                    state_r[c] <= state_d;
                end
            end
        end

        assign free_v  = (free_r[0] & free_r[1]) | (free_r[0] & free_r[2])
                       | (free_r[1] & free_r[2]);
        assign nfree_v = (nfree_r[0] & nfree_r[1]) | (nfree_r[0] & nfree_r[2])
                       | (nfree_r[1] & nfree_r[2]);
        assign state_v = state_t'((state_r[0] & state_r[1]) | (state_r[0] & state_r[2])
                       | (state_r[1] & state_r[2]));
    end else begin : g_simplex
        logic [NBLK-1:0] free_q;
        logic [AW:0]     nfree_q;
        state_t          state_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                free_q  <= '0;
                nfree_q <= '0;
                state_q <= S_INIT;
            end else begin
                free_q  <= free_d;
                nfree_q <= nfree_d;
                state_q <= state_d;
            end
        end

        assign free_v  = free_q;
        assign nfree_v = nfree_q;
        assign state_v = state_q;
    end

    assign READY    = ready_q;
    assign NADR     = nadr_q;
    assign NFREE    = nfree_v;
    assign FULL     = full_q;
    assign FREE_MAP = free_v;
    assign ERR_OVF  = err_ovf_q;
    assign ERR_RLS  = err_rls_q;

endmodule

// File: tb/tb_sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// tb_sca_blk_alloc
//   Three allocator instances sharing clock and reset:
//     u0: RSVD_MASK=16'h8001, MODE 0, simplex
//     u1: RSVD_MASK=0,        MODE 0, TMR
//     u2: RSVD_MASK=0,        MODE 1, simplex
//   Expected outputs are queued when stimulus is applied and compared after
//   the clock edge (or immediately, for asynchronous reset).
// ---------------------------------------------------------------------------
module tb_sca_blk_alloc;

    localparam int F_NADR  = 0;
    localparam int F_NFREE = 1;
    localparam int F_FULL  = 2;
    localparam int F_MAP   = 3;
    localparam int F_OVF   = 4;
    localparam int F_RLS   = 5;
    localparam int F_READY = 6;

    logic        clk;
    logic        rst;
    logic [3:0]  rdadr    [3];
    logic        alloc    [3];
    logic        rls      [3];
    logic [3:0]  rls_adr  [3];
    logic        clr_err  [3];
    logic        ready    [3];
    logic [3:0]  nadr     [3];
    logic [4:0]  nfree    [3];
    logic        full     [3];
    logic [15:0] free_map [3];
    logic        err_ovf  [3];
    logic        err_rls  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sca_blk_alloc #(
            .AW        (4),
            .RSVD_MASK ((g == 0) ? 16'h8001 : 16'h0000),
            .MODE      ((g == 2) ? 1 : 0),
            .TMR       ((g == 1) ? 1 : 0)
        ) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .RDADR    (rdadr[g]),
            .ALLOC    (alloc[g]),
            .RLS      (rls[g]),
            .RLS_ADR  (rls_adr[g]),
            .CLR_ERR  (clr_err[g]),
            .READY    (ready[g]),
            .NADR     (nadr[g]),
            .NFREE    (nfree[g]),
            .FULL     (full[g]),
            .FREE_MAP (free_map[g]),
            .ERR_OVF  (err_ovf[g]),
            .ERR_RLS  (err_rls[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        int          u;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get(input int u, input int f);
        case (f)
            F_NADR:  return 32'(nadr[u]);
            F_NFREE: return 32'(nfree[u]);
            F_FULL:  return 32'(full[u]);
            F_MAP:   return 32'(free_map[u]);
            F_OVF:   return 32'(err_ovf[u]);
            F_RLS:   return 32'(err_rls[u]);
            default: return 32'(ready[u]);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int u, input int f, input logic [31:0] v);
        exp_t e;
        e.tag = $sformatf("u%0d.%s", u, tag);
        e.u   = u;
        e.fld = f;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, get(e.u, e.fld), e.exp);
        end
    endtask

    // One clock: compare queued expectations just after the edge, then drop pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        flush();
        for (int u = 0; u < 3; u++) begin
            alloc[u]   = 1'b0;
            rls[u]     = 1'b0;
            clr_err[u] = 1'b0;
        end
    endtask

    task automatic expect_reset(input int u, input string tag);
        expect_out({tag, "_nfree"}, u, F_NFREE, 0);
        expect_out({tag, "_full"},  u, F_FULL,  1);
        expect_out({tag, "_ready"}, u, F_READY, 0);
        expect_out({tag, "_map"},   u, F_MAP,   0);
        expect_out({tag, "_nadr"},  u, F_NADR,  0);
        expect_out({tag, "_ovf"},   u, F_OVF,   0);
        expect_out({tag, "_rls"},   u, F_RLS,   0);
    endtask

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            alloc[u]   = 1'b0;
            rls[u]     = 1'b0;
            rls_adr[u] = '0;
            clr_err[u] = 1'b0;
        end
        rdadr[0] = 4'h0;
        rdadr[1] = 4'hF;
        rdadr[2] = 4'h7;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) expect_reset(u, "por");
        flush();
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: init sweep takes 16 clocks
        for (int i = 1; i <= 16; i++) begin
            if (i == 15) expect_out("init_ready15", 0, F_READY, 0);
            if (i == 16) begin
                expect_out("init_ready", 0, F_READY, 1);
                expect_out("init_nfree", 0, F_NFREE, 14);
                expect_out("init_map",   0, F_MAP,   16'h7FFE);
                expect_out("init_full",  0, F_FULL,  0);
                expect_out("init_nadr",  0, F_NADR,  1);
                expect_out("init_nfree", 1, F_NFREE, 16);
                expect_out("init_nadr",  1, F_NADR,  0);
                expect_out("init_nfree", 2, F_NFREE, 16);
                expect_out("init_nadr",  2, F_NADR,  0);
            end
            cyc();
        end

        // T2: circular search from RDADR=F, back-to-back allocations
        for (int k = 1; k <= 3; k++) begin
            alloc[1] = 1'b1;
            expect_out("t2_nadr",  1, F_NADR,  k);
            expect_out("t2_nfree", 1, F_NFREE, 16 - k);
            cyc();
        end
        expect_out("t2_map", 1, F_MAP, 16'hFFF8);
        cyc();

        // T3: fill u0, overflow, then ALLOC+RLS while full
        for (int k = 1; k <= 14; k++) begin
            alloc[0] = 1'b1;
            expect_out("t3_nfree", 0, F_NFREE, 14 - k);
            expect_out("t3_nadr",  0, F_NADR,  (k < 14) ? k + 1 : 14);
            cyc();
        end
        expect_out("t3_full", 0, F_FULL, 1);
        expect_out("t3_ovf0", 0, F_OVF,  0);
        cyc();
        alloc[0] = 1'b1;
        expect_out("t3_ovf",      0, F_OVF,   1);
        expect_out("t3_map_keep", 0, F_MAP,   0);
        expect_out("t3_nfree0",   0, F_NFREE, 0);
        cyc();
        alloc[0]   = 1'b1;
        rls[0]     = 1'b1;
        rls_adr[0] = 4'd5;
        expect_out("t3_ar_map",   0, F_MAP,   16'h0020);
        expect_out("t3_ar_nfree", 0, F_NFREE, 1);
        expect_out("t3_ar_full",  0, F_FULL,  0);
        expect_out("t3_ar_nadr",  0, F_NADR,  5);
        cyc();

        // T4: bad releases and error clear
        rls[0] = 1'b1;
        rls_adr[0] = 4'd0;
        expect_out("t4_rsvd_err",   0, F_RLS,   1);
        expect_out("t4_rsvd_nfree", 0, F_NFREE, 1);
        cyc();
        clr_err[0] = 1'b1;
        expect_out("t4_clr_rls", 0, F_RLS, 0);
        expect_out("t4_clr_ovf", 0, F_OVF, 0);
        cyc();
        rls[0] = 1'b1;
        rls_adr[0] = 4'd5;
        expect_out("t4_dbl_err",   0, F_RLS,   1);
        expect_out("t4_dbl_nfree", 0, F_NFREE, 1);
        expect_out("t4_dbl_map",   0, F_MAP,   16'h0020);
        cyc();
        clr_err[0] = 1'b1;
        rls[0]     = 1'b1;
        expect_out("t4_clr_vs_new", 0, F_RLS, 1);
        cyc();
        clr_err[0] = 1'b1;
        expect_out("t4_clr2", 0, F_RLS, 0);
        cyc();

        // T5: MODE 1 lowest-index search, simultaneous ALLOC+RLS
        for (int k = 1; k <= 10; k++) begin
            alloc[2] = 1'b1;
            expect_out("t5_nadr", 2, F_NADR, k);
            cyc();
        end
        expect_out("t5_nfree", 2, F_NFREE, 6);
        expect_out("t5_map",   2, F_MAP,   16'hFC00);
        cyc();
        rls[2] = 1'b1;
        rls_adr[2] = 4'd3;
        expect_out("t5_rls_map",  2, F_MAP,   16'hFC08);
        expect_out("t5_rls_nadr", 2, F_NADR,  3);
        expect_out("t5_rls_nfr",  2, F_NFREE, 7);
        cyc();
        alloc[2]   = 1'b1;
        rls[2]     = 1'b1;
        rls_adr[2] = 4'd9;
        expect_out("t5_sim_nfree", 2, F_NFREE, 7);
        expect_out("t5_sim_map",   2, F_MAP,   16'hFE00);
        expect_out("t5_sim_nadr",  2, F_NADR,  9);
        cyc();

        // T6: reset mid-run (u2 holds 7 free blocks)
        rst = 1'b1;
        #1;
        expect_reset(0, "mid");
        expect_reset(2, "mid");
        flush();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                alloc[1]   = 1'b1;
                rls[1]     = 1'b1;
                rls_adr[1] = 4'd2;
                expect_out("init_alloc_ovf", 1, F_OVF,   1);
                expect_out("init_rls_err",   1, F_RLS,   1);
                expect_out("init_nfree3",    1, F_NFREE, 3);
            end
            if (i == 15) expect_out("re_ready15", 0, F_READY, 0);
            if (i == 16) begin
                expect_out("re_ready", 0, F_READY, 1);
                expect_out("re_nfree", 0, F_NFREE, 14);
                expect_out("re_map",   0, F_MAP,   16'h7FFE);
                expect_out("re_ovf",   0, F_OVF,   0);
                expect_out("re_rls",   0, F_RLS,   0);
                expect_out("re_nfree", 1, F_NFREE, 16);
                expect_out("re_ready", 1, F_READY, 1);
                expect_out("re_nfree", 2, F_NFREE, 16);
                expect_out("re_nadr",  2, F_NADR,  0);
                expect_out("re_ovf",   2, F_OVF,   0);
            end
            cyc();
        end
        clr_err[1] = 1'b1;
        expect_out("clr_ovf", 1, F_OVF, 0);
        expect_out("clr_rls", 1, F_RLS, 0);
        cyc();

        // MODE 0 origin moves: RDADR=5 -> 6; RDADR=14 skips reserved 15 and 0
        rdadr[0] = 4'd5;
        expect_out("org5_nadr", 0, F_NADR, 6);
        cyc();
        rdadr[0] = 4'd14;
        expect_out("org14_nadr", 0, F_NADR, 1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
